collision_detector: RTL and testbench
=====================================

Name: collision_detector

Overview:
- Consumer-side partner of the game loop. It watches the loop's obstacle position, player lane, obstacle gap, and boss laser state, and generates the `dmg` input that the loop samples when it decrements health.
- Registers all hazard decisions, groups each hazard into one event, and applies a post-hit invulnerability window.
- Provides a saturating hit counter and a flash signal for the player-sprite display path.

Parameters:
- INV_CYCLES, 32'd25000000, length of the invulnerability window in cin cycles (0.5 s at 50 MHz).
- FLASH_DIV, 32'd2500000, half-period of hitFlash in cin cycles while invulnerable.

Ports:
- cin  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- power  input  1  run/pause; 0 freezes the block.
- posVal  input  6  obstacle column, one-hot; 6'd32 = player column, 6'd0 = no obstacle.
- charVal  input  2  player lane, 0 = bottom, 3 = top.
- shape  input  2  gap lane of the current obstacle; all other lanes are blocked.
- boss  input  1  boss phase active.
- fireLaser  input  1  laser currently firing.
- laserPos  input  1  laser half: 0 = lanes 0-1, 1 = lanes 2-3.
- dmg  output  1  registered overlap flag, sampled by the loop.
- invuln  output  1  high while in COOLDOWN.
- hitFlash  output  1  blink signal, toggles during COOLDOWN.
- hitCount  output  4  number of damaging events, saturating.

Behaviour:
- One clock, cin. Reset rst is synchronous and active-high.
- On rst: state = IDLE, dmg = 0, invuln = 0, hitFlash = 0, hitCount = 0, all counters = 0. rst overrides power.
- Combinational terms:
  - blkHaz = (posVal == 6'd32) && (charVal != shape).
  - lasHaz = boss && fireLaser && (charVal[1] == laserPos).
  - evt = (posVal == 6'd32) || (boss && fireLaser).
  - haz = blkHaz || lasHaz.
- power = 0: every register, including dmg, holds its value. Nothing advances.
- States: IDLE, EVENT, COOLDOWN. A `hit` flag records whether dmg was asserted during the current event.
- IDLE:
  - dmg <= 0.
  - If evt: go to EVENT, dmg <= haz, hit <= haz.
- EVENT:
  - dmg <= haz, tracking overlap live with 1-cycle latency, so a mid-step dodge clears dmg on the next cycle.
  - hit <= hit | haz.
  - When evt falls:
    - If hit, or if dmg is currently 1: go to COOLDOWN, dmg <= 0, hitCount <= min(hitCount + 1, 15), clear the invulnerability counter, clear the flash counter.
    - Otherwise: go to IDLE.
  - Block and laser events that overlap or abut with no evt-low gap form one event and give one hitCount increment.
- COOLDOWN:
  - dmg = 0. Hazards are ignored and events are not tracked.
  - invuln = 1.
  - The invulnerability counter increments every cycle.
  - hitFlash toggles each time the flash counter reaches FLASH_DIV-1; the flash counter then wraps to 0.
  - When the invulnerability counter reaches INV_CYCLES-1: hitFlash <= 0, invuln <= 0 on the next cycle.
    - If evt is still high: go to EVENT with dmg <= haz, hit <= haz. A hazard that outlasts the window damages again.
    - Otherwise: go to IDLE.
- Latency: hazard onset in IDLE or EVENT produces dmg = 1 on the following cycle.
- hitCount saturates at 4'd15; it never wraps.
- Non-one-hot posVal values other than 32 are treated as no block hazard.

Test Plan:
All scenarios use INV_CYCLES = 8 and FLASH_DIV = 2.
- Reset / pause: assert rst with power = 1 and posVal = 32, charVal = 1, shape = 2 → next cycle dmg = 0, invuln = 0, hitCount = 0. Then drive power = 0 with a hazard present → dmg and state stay unchanged.
- Block hit:
  - Hold posVal = 32, charVal = 1, shape = 2 for 5 cycles → dmg = 1 from cycle 2 to cycle 5.
  - Then drive posVal = 0 → dmg = 0, invuln = 1 for 8 cycles, hitCount = 1, hitFlash toggles every 2 cycles and ends at 0.
- Dodge: posVal = 32, charVal = 2, shape = 2 → dmg stays 0, hitCount stays 0, no COOLDOWN. Next, a mid-event move from charVal = 1 to charVal = 2 → dmg falls 1 cycle after the move, and hitCount still increments at event end.
- Laser: boss = 1, fireLaser = 1, laserPos = 1 with charVal = 3 → dmg = 1. The same setup with charVal = 0 → dmg = 0. A laser event directly after a block event (no gap) → only one increment, hitCount = 1.
- Window expiry: hold a hazard for 20 cycles → dmg pulses again when COOLDOWN ends, and hitCount increments a second time when the event finally ends.
- Saturation: drive 17 separate damaging events → hitCount = 15.

Source files
------------

// File: rtl/collision_detector.sv
// collision_detector: turns the game loop's obstacle, lane and laser state into
// a registered damage flag. Each hazard episode is grouped into one event, a hit
// opens an invulnerability window with a blinking sprite flag, and a saturating
// counter records how many damaging events have occurred.
module collision_detector #(
    parameter logic [31:0] INV_CYCLES = 32'd25000000,
    parameter logic [31:0] FLASH_DIV  = 32'd2500000
) (
    input  logic       cin,
    input  logic       rst,
    input  logic       power,
    input  logic [5:0] posVal,
    input  logic [1:0] charVal,
    input  logic [1:0] shape,
    input  logic       boss,
    input  logic       fireLaser,
    input  logic       laserPos,
    output logic       dmg,
    output logic       invuln,
    output logic       hitFlash,
    output logic [3:0] hitCount
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVENT    = 2'd1,
        COOLDOWN = 2'd2
    } stateT;

    stateT       r_state;
    logic        r_dmg;
    logic        r_hit;
    logic [31:0] r_invCnt;
    logic [31:0] r_flashCnt;
    logic        r_flash;
    logic [3:0]  r_hitCount;

    stateT       w_nextState;
    logic        w_nextDmg;
    logic        w_nextHit;
    logic [31:0] w_nextInvCnt;
    logic [31:0] w_nextFlashCnt;
    logic        w_nextFlash;
    logic [3:0]  w_nextHitCount;

    logic        w_blkHaz;
    logic        w_lasHaz;
    logic        w_evt;
    logic        w_haz;

    // Hazard terms: a block at the player's column with the player outside the
    // gap, or an active laser sweeping the player's half of the screen.
    always_comb begin
        w_blkHaz = (posVal == 6'd32) && (charVal != shape);
        w_lasHaz = boss && fireLaser && (charVal[1] == laserPos);
        w_evt    = (posVal == 6'd32) || (boss && fireLaser);
        w_haz    = w_blkHaz || w_lasHaz;
    end

    // Next-state logic: event grouping, hit bookkeeping and the cooldown timers.
    always_comb begin
        w_nextState    = r_state;
        w_nextDmg      = r_dmg;
        w_nextHit      = r_hit;
        w_nextInvCnt   = r_invCnt;
        w_nextFlashCnt = r_flashCnt;
        w_nextFlash    = r_flash;
        w_nextHitCount = r_hitCount;

        case (r_state)
            IDLE: begin
                w_nextDmg = 1'b0;
                if (w_evt) begin
                    w_nextState = EVENT;
                    w_nextDmg   = w_haz;
                    w_nextHit   = w_haz;
                end
            end

            EVENT: begin
                if (w_evt) begin
                    w_nextDmg = w_haz;
                    w_nextHit = r_hit | w_haz;
                end else if (r_hit || r_dmg) begin
                    w_nextState    = COOLDOWN;
                    w_nextDmg      = 1'b0;
                    w_nextInvCnt   = 32'd0;
                    w_nextFlashCnt = 32'd0;
                    w_nextFlash    = 1'b0;
                    if (r_hitCount != 4'd15) begin
                        w_nextHitCount = r_hitCount + 4'd1;
                    end
                end else begin
                    w_nextState = IDLE;
                    w_nextDmg   = 1'b0;
                end
            end

            COOLDOWN: begin
                w_nextDmg = 1'b0;
                if (r_invCnt == INV_CYCLES - 32'd1) begin
                    w_nextFlash = 1'b0;
                    if (w_evt) begin
                        w_nextState = EVENT;
                        w_nextDmg   = w_haz;
                        w_nextHit   = w_haz;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextInvCnt = r_invCnt + 32'd1;
                    if (r_flashCnt == FLASH_DIV - 32'd1) begin
                        w_nextFlash    = ~r_flash;
                        w_nextFlashCnt = 32'd0;
                    end else begin
                        w_nextFlashCnt = r_flashCnt + 32'd1;
                    end
                end
            end

            default: begin
                w_nextState = IDLE;
                w_nextDmg   = 1'b0;
            end
        endcase
    end

    // State register: reset wins, and a low power input freezes every register.
    always_ff @(posedge cin) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dmg      <= 1'b0;
            r_hit      <= 1'b0;
            r_invCnt   <= 32'd0;
            r_flashCnt <= 32'd0;
            r_flash    <= 1'b0;
            r_hitCount <= 4'd0;
        end else if (power) begin
            r_state    <= w_nextState;
            r_dmg      <= w_nextDmg;
            r_hit      <= w_nextHit;
            r_invCnt   <= w_nextInvCnt;
            r_flashCnt <= w_nextFlashCnt;
            r_flash    <= w_nextFlash;
            r_hitCount <= w_nextHitCount;
        end
    end

    assign dmg      = r_dmg;
    assign invuln   = (r_state == COOLDOWN);
    assign hitFlash = r_flash;
    assign hitCount = r_hitCount;

endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: drives the collision detector through reset, pause,
// block hits, dodges, lasers, window expiry and counter saturation, comparing
// every cycle against a behavioural scoreboard plus hand-derived checkpoints.
module tb_collision_detector;

    localparam int INV = 8;
    localparam int FD  = 2;

    logic       cin;
    logic       rst;
    logic       power;
    logic [5:0] posVal;
    logic [1:0] charVal;
    logic [1:0] shape;
    logic       boss;
    logic       fireLaser;
    logic       laserPos;
    logic       dmg;
    logic       invuln;
    logic       hitFlash;
    logic [3:0] hitCount;

    typedef struct {
        logic       dmg;
        logic       invuln;
        logic       flash;
        logic [3:0] cnt;
    } expT;

    expT expQ[$];

    int compareCount  = 0;
    int mismatchCount = 0;

    int   mState;
    logic mDmg;
    logic mHit;
    int   mInv;
    int   mFl;
    logic mFlash;
    int   mCount;

    collision_detector #(
        .INV_CYCLES(32'd8),
        .FLASH_DIV (32'd2)
    ) dut (
        .cin      (cin),
        .rst      (rst),
        .power    (power),
        .posVal   (posVal),
        .charVal  (charVal),
        .shape    (shape),
        .boss     (boss),
        .fireLaser(fireLaser),
        .laserPos (laserPos),
        .dmg      (dmg),
        .invuln   (invuln),
        .hitFlash (hitFlash),
        .hitCount (hitCount)
    );

    // Free-running system clock.
    initial begin
        cin = 1'b0;
        forever #5 cin = ~cin;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Behavioural model evaluated with the inputs present at the coming edge.
    task automatic modelStep();
        logic blk, las, ev, hz;
        blk = (posVal == 6'd32) && (charVal != shape);
        las = boss && fireLaser && (charVal[1] == laserPos);
        ev  = (posVal == 6'd32) || (boss && fireLaser);
        hz  = blk || las;
        if (rst) begin
            mState = 0; mDmg = 0; mHit = 0; mInv = 0; mFl = 0; mFlash = 0; mCount = 0;
        end else if (power) begin
            case (mState)
                0: begin
                    mDmg = 0;
                    if (ev) begin
                        mState = 1; mDmg = hz; mHit = hz;
                    end
                end
                1: begin
                    if (ev) begin
                        mDmg = hz; mHit = mHit | hz;
                    end else if (mHit || mDmg) begin
                        mState = 2; mDmg = 0; mInv = 0; mFl = 0; mFlash = 0;
                        mCount = (mCount == 15) ? 15 : mCount + 1;
                    end else begin
                        mState = 0; mDmg = 0;
                    end
                end
                default: begin
                    mDmg = 0;
                    if (mInv == INV - 1) begin
                        mFlash = 0;
                        if (ev) begin
                            mState = 1; mDmg = hz; mHit = hz;
                        end else begin
                            mState = 0;
                        end
                    end else begin
                        mInv++;
                        if (mFl == FD - 1) begin
                            mFlash = ~mFlash; mFl = 0;
                        end else begin
                            mFl++;
                        end
                    end
                end
            endcase
        end
    endtask

    // Runs n clock cycles with the current inputs, scoreboarding every cycle.
    task automatic applyStimulus(input int n);
        expT e;
        for (int i = 0; i < n; i++) begin
            modelStep();
            e.dmg    = mDmg;
            e.invuln = (mState == 2);
            e.flash  = mFlash;
            e.cnt    = 4'(mCount);
            expQ.push_back(e);
            @(posedge cin);
            #1;
            e = expQ.pop_front();
            checkOutput("sbDmg",      {31'd0, dmg},      {31'd0, e.dmg});
            checkOutput("sbInvuln",   {31'd0, invuln},   {31'd0, e.invuln});
            checkOutput("sbHitFlash", {31'd0, hitFlash}, {31'd0, e.flash});
            checkOutput("sbHitCount", {28'd0, hitCount}, {28'd0, e.cnt});
        end
    endtask

    task automatic setBlock(input logic [5:0] p, input logic [1:0] c, input logic [1:0] s);
        posVal = p; charVal = c; shape = s;
    endtask

    // Main scenario sequence.
    initial begin
        rst = 1'b1; power = 1'b1;
        setBlock(6'd32, 2'd1, 2'd2);
        boss = 1'b0; fireLaser = 1'b0; laserPos = 1'b0;
        mState = 0; mDmg = 0; mHit = 0; mInv = 0; mFl = 0; mFlash = 0; mCount = 0;

        // Reset overrides a present hazard.
        applyStimulus(2);
        checkOutput("rstDmg",      {31'd0, dmg},      32'd0);
        checkOutput("rstInvuln",   {31'd0, invuln},   32'd0);
        checkOutput("rstHitCount", {28'd0, hitCount}, 32'd0);

        // Pause with the hazard present: nothing moves.
        rst = 1'b0; power = 1'b0;
        applyStimulus(3);
        checkOutput("pauseDmg", {31'd0, dmg}, 32'd0);
        power = 1'b1;

        // Block hit held five cycles, then cleared.
        applyStimulus(1);
        checkOutput("blockDmgOn", {31'd0, dmg}, 32'd1);
        applyStimulus(4);
        setBlock(6'd0, 2'd1, 2'd2);
        applyStimulus(1);
        checkOutput("blockCooldown", {31'd0, invuln},   32'd1);
        checkOutput("blockCount",    {28'd0, hitCount}, 32'd1);
        applyStimulus(8);
        checkOutput("blockWinEnd",   {31'd0, invuln},   32'd0);
        checkOutput("blockFlashEnd", {31'd0, hitFlash}, 32'd0);

        // Dodge through the gap.
        setBlock(6'd32, 2'd2, 2'd2);
        applyStimulus(3);
        setBlock(6'd0, 2'd2, 2'd2);
        applyStimulus(1);
        checkOutput("dodgeCount",  {28'd0, hitCount}, 32'd1);
        checkOutput("dodgeInvuln", {31'd0, invuln},   32'd0);

        // Mid-event dodge: dmg clears, the event still counts.
        setBlock(6'd32, 2'd1, 2'd2);
        applyStimulus(2);
        setBlock(6'd32, 2'd2, 2'd2);
        applyStimulus(1);
        checkOutput("midDodgeDmg", {31'd0, dmg}, 32'd0);
        applyStimulus(1);
        setBlock(6'd0, 2'd2, 2'd2);
        applyStimulus(1);
        checkOutput("midDodgeCount", {28'd0, hitCount}, 32'd2);
        applyStimulus(8);

        // Laser on the player's half.
        boss = 1'b1; fireLaser = 1'b1; laserPos = 1'b1; charVal = 2'd3;
        applyStimulus(2);
        checkOutput("laserDmg", {31'd0, dmg}, 32'd1);
        fireLaser = 1'b0;
        applyStimulus(1);
        checkOutput("laserCount", {28'd0, hitCount}, 32'd3);
        applyStimulus(8);

        // Laser on the other half.
        charVal = 2'd0; fireLaser = 1'b1;
        applyStimulus(2);
        checkOutput("laserMissDmg", {31'd0, dmg}, 32'd0);
        fireLaser = 1'b0;
        applyStimulus(1);
        checkOutput("laserMissCount", {28'd0, hitCount}, 32'd3);

        // Block then laser with no gap: one event.
        setBlock(6'd32, 2'd3, 2'd0);
        applyStimulus(2);
        setBlock(6'd0, 2'd3, 2'd0);
        fireLaser = 1'b1;
        applyStimulus(2);
        fireLaser = 1'b0;
        applyStimulus(1);
        checkOutput("mergedCount", {28'd0, hitCount}, 32'd4);
        applyStimulus(8);
        boss = 1'b0;

        // Hazard outlasting the invulnerability window.
        setBlock(6'd32, 2'd1, 2'd2);
        applyStimulus(2);
        setBlock(6'd0, 2'd1, 2'd2);
        applyStimulus(1);
        setBlock(6'd32, 2'd1, 2'd2);
        applyStimulus(7);
        checkOutput("winHeldDmg",    {31'd0, dmg},    32'd0);
        checkOutput("winHeldInvuln", {31'd0, invuln}, 32'd1);
        applyStimulus(1);
        checkOutput("winReDmg",    {31'd0, dmg},    32'd1);
        checkOutput("winReInvuln", {31'd0, invuln}, 32'd0);
        applyStimulus(12);
        setBlock(6'd0, 2'd1, 2'd2);
        applyStimulus(1);
        checkOutput("winCount", {28'd0, hitCount}, 32'd6);
        applyStimulus(8);

        // Seventeen separate damaging events saturate the counter.
        for (int k = 0; k < 17; k++) begin
            setBlock(6'd32, 2'd1, 2'd2);
            applyStimulus(1);
            setBlock(6'd0, 2'd1, 2'd2);
            applyStimulus(9);
        end
        checkOutput("satCount", {28'd0, hitCount}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
